// File: rtl/acc_mmu_arb_pkg.sv
// Shared types for the accelerator MMU translation-port arbiter.
package acc_mmu_arb_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 64;

    // Same field layout as ariane_pkg::exception_t so the port maps straight onto the core.
    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef enum logic [1:0] {
        IDLE,
        XLATE,
        RESP
    } state_e;

    typedef struct packed {
        logic [VLEN-1:0] vaddr;
        logic            is_store;
        exception_t      misaligned_ex;
    } payload_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_mmu_rr_sel.sv
// Combinational round-robin picker: first requester strictly after rr_ptr, wrapping.
module acc_mmu_rr_sel
    import acc_mmu_arb_pkg::*;
#(
    parameter  int unsigned NrPorts = 2,
    localparam int unsigned IdxW    = idx_width(NrPorts)
) (
    input  logic [NrPorts-1:0] req_i,
    input  logic [IdxW-1:0]    rr_ptr_i,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
);

    localparam int unsigned CandW = IdxW + 1;

    logic [CandW-1:0] cand;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NrPorts; i++) begin
            cand = CandW'(rr_ptr_i) + CandW'(i);
            if (cand >= CandW'(NrPorts)) begin
                cand = cand - CandW'(NrPorts);
            end
            if (!gnt_valid_o && req_i[cand[IdxW-1:0]]) begin
                gnt_idx_o   = cand[IdxW-1:0];
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_mmu_arbiter.sv
// Shares the core's single accelerator MMU translation port between NrPorts requesters.
// One translation in flight, round-robin grant, results steered to the owner, watchdog flag.
module acc_mmu_arbiter
    import acc_mmu_arb_pkg::*;
#(
    parameter int unsigned NrPorts       = 2,
    parameter int unsigned VLen          = 64,
    parameter int unsigned PLen          = 56,
    parameter int unsigned PpnW          = 44,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NrPorts-1:0]           req_i,
    input  logic [NrPorts-1:0][VLen-1:0] vaddr_i,
    input  logic [NrPorts-1:0]           is_store_i,
    input  exception_t [NrPorts-1:0]     misaligned_ex_i,
    output logic [NrPorts-1:0]           dtlb_hit_o,
    output logic [PpnW-1:0]              dtlb_ppn_o,
    output logic [NrPorts-1:0]           resp_valid_o,
    output logic [PLen-1:0]              resp_paddr_o,
    output exception_t                   resp_ex_o,
    output logic                         mmu_req_o,
    output logic [VLen-1:0]              mmu_vaddr_o,
    output logic                         mmu_is_store_o,
    output exception_t                   mmu_misaligned_ex_o,
    input  logic                         mmu_dtlb_hit_i,
    input  logic [PpnW-1:0]              mmu_dtlb_ppn_i,
    input  logic                         mmu_valid_i,
    input  logic [PLen-1:0]              mmu_paddr_i,
    input  exception_t                   mmu_ex_i,
    output logic                         timeout_o
);

    localparam int unsigned IdxW  = idx_width(NrPorts);
    localparam int unsigned WdogW = $clog2(TimeoutCycles + 1);

    state_e           state_q,   state_d;
    logic [IdxW-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IdxW-1:0]  rr_ptr_q,  rr_ptr_d;
    payload_t         payload_q, payload_d;
    logic             drop_q,    drop_d;
    logic [WdogW-1:0] wdog_q,    wdog_d;
    logic             timeout_q, timeout_d;
    logic [PLen-1:0]  paddr_q,   paddr_d;
    exception_t       ex_q,      ex_d;

    logic [IdxW-1:0]  sel_idx;
    logic             sel_valid;

    acc_mmu_rr_sel #(
        .NrPorts (NrPorts)
    ) u_rr_sel (
        .req_i       (req_i),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_idx_o   (sel_idx),
        .gnt_valid_o (sel_valid)
    );

    // Next-state: grant, translate, respond; the walk is never aborted, only its result dropped.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        payload_d = payload_q;
        drop_d    = drop_q;
        wdog_d    = '0;
        timeout_d = timeout_q;
        paddr_d   = paddr_q;
        ex_d      = ex_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid && !flush_i) begin
                    gnt_idx_d = sel_idx;
                    rr_ptr_d  = sel_idx;
                    payload_d = '{vaddr:         VLEN'(vaddr_i[sel_idx]),
                                  is_store:      is_store_i[sel_idx],
                                  misaligned_ex: misaligned_ex_i[sel_idx]};
                    state_d   = XLATE;
                end
            end
            XLATE: begin
                if (flush_i || !req_i[gnt_idx_q]) begin
                    drop_d = 1'b1;
                end
                if (mmu_valid_i) begin
                    paddr_d = mmu_paddr_i;
                    ex_d    = mmu_ex_i;
                    state_d = RESP;
                end else begin
                    wdog_d = (wdog_q == WdogW'(TimeoutCycles)) ? wdog_q : wdog_q + WdogW'(1);
                    if (wdog_d == WdogW'(TimeoutCycles)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            RESP: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IdxW'(NrPorts - 1);
            payload_q <= '0;
            drop_q    <= 1'b0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            paddr_q   <= '0;
            ex_q      <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            payload_q <= payload_d;
            drop_q    <= drop_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            paddr_q   <= paddr_d;
            ex_q      <= ex_d;
        end
    end

    // DTLB hit is zero-latency; the result pulse can still be killed by a same-cycle flush.
    always_comb begin
        dtlb_hit_o   = '0;
        resp_valid_o = '0;
        if (state_q == XLATE) begin
            dtlb_hit_o[gnt_idx_q] = mmu_dtlb_hit_i;
        end
        if (state_q == RESP && !drop_q && !flush_i) begin
            resp_valid_o[gnt_idx_q] = 1'b1;
        end
    end

    assign dtlb_ppn_o          = (state_q == XLATE) ? mmu_dtlb_ppn_i : '0;
    assign mmu_req_o           = (state_q == XLATE);
    assign mmu_vaddr_o         = VLen'(payload_q.vaddr);
    assign mmu_is_store_o      = payload_q.is_store;
    assign mmu_misaligned_ex_o = payload_q.misaligned_ex;
    assign resp_paddr_o        = paddr_q;
    assign resp_ex_o           = ex_q;
    assign timeout_o           = timeout_q;

endmodule
